// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one IMEM request outstanding, and holds the fetched word while ID stalls.
// Applies branch/jump/exception redirects with MIPS delay-slot ordering.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_Stall,
  input  logic        Flush,
  input  logic        Exception,
  input  logic        ID_IsBranchOrJump,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JumpRegTarget,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ack,
  input  logic [31:0] IMEM_RData,
  output logic [31:0] IF_Instruction,
  output logic [31:0] PCAdd4,
  output logic [31:0] PCOut,
  output logic        IF_IsBDS,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        dbg_state
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_target;
  logic        redir_pending;
  logic        bds_pending;
  logic        discard_pending;
  logic [31:0] hold_buf;

  logic [31:0] pc_add4;
  logic [31:0] raw_target;
  logic [31:0] sel_target;
  logic [31:0] next_pc;
  logic        advance;
  logic        br_in_id;
  logic        br_leave;

  // IMEM handshake: IMEM_Req rises with IMEM_Addr and both stay unchanged until the cycle
  // IMEM_Ack is high; IMEM_RData is valid only in that cycle, and the request drops or moves
  // to the next address on the following edge.
  assign pc_add4   = pc + 32'd4;
  assign advance   = ((state == S_REQ && IMEM_Ack) || state == S_HOLD) && !ID_Stall;
  assign br_in_id  = ID_IsBranchOrJump && !ID_Stall;
  assign br_leave  = br_in_id && (PCSrc != 2'b00) && !discard_pending;
  assign dbg_state = state;

  always_comb begin
    raw_target = BranchTarget;
    case (PCSrc)
      2'b10:   raw_target = JumpTarget;
      2'b11:   raw_target = JumpRegTarget;
      default: raw_target = BranchTarget;
    endcase
  end

  assign sel_target = {raw_target[31:2], 2'b00};

  // A branch leaving ID together with its delay slot leaving IF redirects immediately;
  // otherwise the target waits in redir_target until the delay slot is delivered.
  always_comb begin
    if (discard_pending || Exception) next_pc = EXC_VECTOR;
    else if (br_leave)                next_pc = sel_target;
    else if (redir_pending)           next_pc = redir_target;
    else                              next_pc = pc_add4;
  end

  assign IMEM_Req       = RST && (state == S_REQ);
  assign IMEM_Addr      = {pc[31:2], 2'b00};
  assign IF_Stall       = !RST || (state == S_REQ && !IMEM_Ack);
  assign IF_Flush       = RST && (Flush || discard_pending || Exception);
  assign IF_IsBDS       = !IF_Stall && (ID_IsBranchOrJump || bds_pending);
  assign PCOut          = pc;
  assign PCAdd4         = pc_add4;

  always_comb begin
    IF_Instruction = 32'd0;
    if (RST) begin
      if (state == S_HOLD)  IF_Instruction = hold_buf;
      else if (IMEM_Ack)    IF_Instruction = IMEM_RData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= S_REQ;
      pc              <= RESET_VECTOR;
      redir_target    <= 32'd0;
      redir_pending   <= 1'b0;
      bds_pending     <= 1'b0;
      discard_pending <= 1'b0;
      hold_buf        <= 32'd0;
    end else if (Exception) begin
      redir_pending <= 1'b0;
      bds_pending   <= 1'b0;
      // An in-flight request cannot be retargeted, so its word is squashed when it returns.
      if (state == S_REQ && !IMEM_Ack) begin
        discard_pending <= 1'b1;
      end else begin
        discard_pending <= 1'b0;
        pc              <= EXC_VECTOR;
        state           <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (IMEM_Ack) begin
            if (!ID_Stall) begin
              pc <= next_pc;
            end else begin
              hold_buf <= IMEM_RData;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!ID_Stall) begin
            pc    <= next_pc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (advance) begin
        redir_pending   <= 1'b0;
        bds_pending     <= 1'b0;
        discard_pending <= 1'b0;
      end else begin
        if (br_leave) begin
          redir_target  <= sel_target;
          redir_pending <= 1'b1;
        end
        if (br_in_id && !discard_pending) bds_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory responder with programmable ack latency,
// a cycle driver for ID-side inputs, and a scoreboard monitor checking each delivered instruction.
module tb_if_fetch_stage;

  localparam int W = 66;  // {pc, instruction, is_bds, flush}

  logic        CLK;
  logic        RST;
  logic        ID_Stall;
  logic        Flush;
  logic        Exception;
  logic        ID_IsBranchOrJump;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JumpRegTarget;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ack;
  logic [31:0] IMEM_RData;
  logic [31:0] IF_Instruction;
  logic [31:0] PCAdd4;
  logic [31:0] PCOut;
  logic        IF_IsBDS;
  logic        IF_Stall;
  logic        IF_Flush;
  logic        dbg_state;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int ack_delay;

  if_fetch_stage dut (
    .CLK(CLK), .RST(RST), .ID_Stall(ID_Stall), .Flush(Flush), .Exception(Exception),
    .ID_IsBranchOrJump(ID_IsBranchOrJump), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .JumpTarget(JumpTarget), .JumpRegTarget(JumpRegTarget), .IMEM_Req(IMEM_Req),
    .IMEM_Addr(IMEM_Addr), .IMEM_Ack(IMEM_Ack), .IMEM_RData(IMEM_RData),
    .IF_Instruction(IF_Instruction), .PCAdd4(PCAdd4), .PCOut(PCOut), .IF_IsBDS(IF_IsBDS),
    .IF_Stall(IF_Stall), .IF_Flush(IF_Flush), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic bds, input logic fl);
    exp_q.push_back({pc, mem_word(pc), bds, fl});
  endtask

  // One ID-side cycle: inputs change at the falling edge; returns 2 time units later.
  task automatic cyc(input logic stall, input logic br, input logic [1:0] src,
                     input logic [31:0] tgt, input logic exc, input logic fl);
    @(negedge CLK);
    ID_Stall          = stall;
    ID_IsBranchOrJump = br;
    PCSrc             = src;
    BranchTarget      = (src == 2'b01) ? tgt : 32'hDEAD_0001;
    JumpTarget        = (src == 2'b10) ? tgt : 32'hDEAD_0002;
    JumpRegTarget     = (src == 2'b11) ? tgt : 32'hDEAD_0003;
    Exception         = exc;
    Flush             = fl;
    #2;
  endtask

  task automatic plain();
    cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic        pending;
    logic [31:0] req_addr;
    int          wait_cnt;
    int          lat;
    pending    = 1'b0;
    req_addr   = 32'd0;
    wait_cnt   = 0;
    lat        = 0;
    IMEM_Ack   = 1'b0;
    IMEM_RData = 32'd0;
    forever begin
      @(negedge CLK);
      if (RST && IMEM_Req) begin
        if (!pending) begin
          pending  = 1'b1;
          req_addr = IMEM_Addr;
          wait_cnt = 0;
          lat      = ack_delay;
        end
        if (IMEM_Addr !== req_addr) begin
          checks++;
          errors++;
          $display("FAIL req_addr_stable: got %h expected %h", IMEM_Addr, req_addr);
        end
        if (wait_cnt == lat) begin
          IMEM_Ack   = 1'b1;
          IMEM_RData = mem_word(IMEM_Addr);
          pending    = 1'b0;
        end else begin
          IMEM_Ack   = 1'b0;
          IMEM_RData = 32'hXXXX_XXXX;
          wait_cnt++;
        end
      end else begin
        IMEM_Ack   = 1'b0;
        IMEM_RData = 32'd0;
        pending    = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge CLK);
      #2;
      if (RST && !IF_Stall && !ID_Stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pc %h with nothing expected", PCOut);
        end else begin
          e = exp_q.pop_front();
          a = {PCOut, IF_Instruction, IF_IsBDS, IF_Flush};
          if (a !== e) begin
            errors++;
            $display("FAIL delivered: got pc=%h ins=%h bds=%b flush=%b expected pc=%h ins=%h bds=%b flush=%b",
                     a[65:34], a[33:2], a[1], a[0], e[65:34], e[33:2], e[1], e[0]);
          end
          chk("pcadd4", PCAdd4, e[65:34] + 32'd4);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    checks            = 0;
    errors            = 0;
    ack_delay         = 0;
    RST               = 1'b0;
    ID_Stall          = 1'b0;
    Flush             = 1'b0;
    Exception         = 1'b0;
    ID_IsBranchOrJump = 1'b0;
    PCSrc             = 2'b00;
    BranchTarget      = 32'd0;
    JumpTarget        = 32'd0;
    JumpRegTarget     = 32'd0;

    repeat (2) @(negedge CLK);
    #2;
    chk("rst_req",   {31'd0, IMEM_Req}, 32'd0);
    chk("rst_stall", {31'd0, IF_Stall}, 32'd1);
    chk("rst_flush", {31'd0, IF_Flush}, 32'd0);
    chk("rst_instr", IF_Instruction, 32'd0);
    chk("rst_bds",   {31'd0, IF_IsBDS}, 32'd0);
    chk("rst_pc",    PCOut, 32'hBFC0_0000);
    @(posedge CLK);
    #1 RST = 1'b1;

    // zero-wait streaming
    push(32'hBFC0_0000, 1'b0, 1'b0);
    push(32'hBFC0_0004, 1'b0, 1'b0);
    push(32'hBFC0_0008, 1'b0, 1'b0);
    plain();
    chk("seq_addr0", PCAdd4, 32'hBFC0_0004);
    plain();
    plain();
    idle();                                   // 0xBFC0000C captured into HOLD

    // HOLD while ID stalls
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("hold_req",   {31'd0, IMEM_Req}, 32'd0);
      chk("hold_instr", IF_Instruction, mem_word(32'hBFC0_000C));
      chk("hold_pc",    PCOut, 32'hBFC0_000C);
      chk("hold_stall", {31'd0, IF_Stall}, 32'd0);
    end
    push(32'hBFC0_000C, 1'b0, 1'b0);
    plain();

    // jump to 0x100, then branch at 0x100 to 0x200 with delay slot 0x104
    push(32'hBFC0_0010, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
    push(32'h0000_0100, 1'b0, 1'b0);
    plain();
    push(32'h0000_0104, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 32'h0000_0200, 1'b0, 1'b0);
    push(32'h0000_0200, 1'b0, 1'b0);
    plain();
    idle();
    ack_delay = 3;

    // three-cycle memory latency
    push(32'h0000_0204, 1'b0, 1'b0);
    plain();
    for (int i = 0; i < 3; i++) begin
      plain();
      chk("lat_stall", {31'd0, IF_Stall}, 32'd1);
      chk("lat_addr",  IMEM_Addr, 32'h0000_0208);
      ack_delay = 0;
    end
    push(32'h0000_0208, 1'b0, 1'b0);
    plain();

    // branch while IF waits two cycles for its delay slot
    push(32'h0000_020C, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
    push(32'h0000_0100, 1'b0, 1'b0);
    plain();
    ack_delay = 2;
    cyc(1'b0, 1'b1, 2'b01, 32'h0000_0200, 1'b0, 1'b0);
    chk("bubble_stall", {31'd0, IF_Stall}, 32'd1);
    chk("bubble_bds",   {31'd0, IF_IsBDS}, 32'd0);
    ack_delay = 0;
    plain();
    push(32'h0000_0104, 1'b1, 1'b0);
    plain();
    push(32'h0000_0200, 1'b0, 1'b0);
    plain();
    idle();
    ack_delay = 3;

    // exception during an outstanding request, with a competing branch
    push(32'h0000_0204, 1'b0, 1'b0);
    plain();
    cyc(1'b0, 1'b1, 2'b01, 32'h0000_0300, 1'b1, 1'b0);
    chk("exc_flush", {31'd0, IF_Flush}, 32'd1);
    chk("exc_stall", {31'd0, IF_Stall}, 32'd1);
    ack_delay = 0;
    plain();
    plain();
    push(32'h0000_0208, 1'b0, 1'b1);
    plain();
    push(32'h8000_0180, 1'b0, 1'b0);
    plain();
    push(32'h8000_0184, 1'b0, 1'b0);
    plain();
    idle();

    // exception while held with ID still stalled
    cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 1'b0);
    chk("hold_exc_flush", {31'd0, IF_Flush}, 32'd1);
    idle();
    chk("hold_exc_pc",    PCOut, 32'h8000_0180);
    chk("hold_exc_clear", {31'd0, IF_Flush}, 32'd0);

    // Flush while advancing, PC wrap, JR with misaligned register target
    push(32'h8000_0180, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    push(32'h8000_0184, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, 1'b0, 1'b0);
    push(32'hFFFF_FFFC, 1'b0, 1'b0);
    plain();
    push(32'h0000_0000, 1'b0, 1'b0);
    plain();
    push(32'h0000_0004, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b11, 32'h0000_0403, 1'b0, 1'b0);
    push(32'h0000_0400, 1'b0, 1'b0);
    plain();
    idle();
    idle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
